// File: rtl/fir_pkg.sv
// Shared types and helpers for the n_tap_fir_stream filter family:
// FSM state encoding, accumulator sizing and output clipping.
package fir_pkg;

    typedef logic [1:0] fir_state_t;

    localparam fir_state_t ST_IDLE  = 2'd0;
    localparam fir_state_t ST_LOAD  = 2'd1;
    localparam fir_state_t ST_RUN   = 2'd2;
    localparam fir_state_t ST_FLUSH = 2'd3;

    // Worst-case growth: one full product plus log2 of the number of summed taps.
    function automatic int acc_width(input int data_w, input int coeff_w, input int taps);
        return data_w + coeff_w + $clog2(taps);
    endfunction

    // Clip a sign-extended value into the signed range of out_w bits (out_w <= 64).
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int out_w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/n_tap_fir_stream_if.sv
// Coefficient-load, sample-in and sample-out signals of n_tap_fir_stream.
// master drives samples/coefficients, slave is the filter.
interface n_tap_fir_stream_if #(
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int OUT_WIDTH   = 16
);
    logic                          loadCoeff;
    logic                          coeffValid;
    logic signed [COEFF_WIDTH-1:0] coeffIn;
    logic                          coeffSetFlag;
    logic                          dataValid;
    logic                          dataInReady;
    logic signed [DATA_WIDTH-1:0]  dataIn;
    logic                          stopDataLoadFlag;
    logic                          dataOutValid;
    logic signed [OUT_WIDTH-1:0]   dataOut;
    logic                          flushDone;

    modport master (
        output loadCoeff, coeffValid, coeffIn, dataValid, dataIn, stopDataLoadFlag,
        input  coeffSetFlag, dataInReady, dataOutValid, dataOut, flushDone
    );

    modport slave (
        input  loadCoeff, coeffValid, coeffIn, dataValid, dataIn, stopDataLoadFlag,
        output coeffSetFlag, dataInReady, dataOutValid, dataOut, flushDone
    );

endinterface

// File: rtl/fir_sat_shift.sv
// Output stage of the FIR: floor arithmetic right shift of the accumulator,
// clip to OUT_WIDTH and register together with valid/last.
module fir_sat_shift
    import fir_pkg::*;
#(
    parameter int ACC_WIDTH = 20,
    parameter int OUT_WIDTH = 16,
    parameter int SHIFT     = 0
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        clear,
    input  logic                        vld_p1,
    input  logic                        last_p1,
    input  logic signed [ACC_WIDTH-1:0] acc_p1,
    output logic                        vld_p2,
    output logic                        last_p2,
    output logic signed [OUT_WIDTH-1:0] data_p2
);

    logic signed [ACC_WIDTH-1:0] shifted;
    logic signed [63:0]          clipped;

    always_comb begin
        shifted = acc_p1 >>> SHIFT;
        clipped = saturate(64'(shifted), OUT_WIDTH);
    end

    // Stage 2: shift/saturate register; clear drops whatever is in flight.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_p2  <= 1'b0;
            last_p2 <= 1'b0;
            data_p2 <= '0;
        end else begin
            vld_p2  <= vld_p1 & ~clear;
            last_p2 <= vld_p1 & last_p1 & ~clear;
            if (vld_p1) data_p2 <= clipped[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/n_tap_fir_stream.sv
// Streaming transposed-form FIR with coefficient-load FSM, zero-padding flush
// and a two-register output pipeline (accumulate, then shift/saturate).
module n_tap_fir_stream
    import fir_pkg::*;
#(
    parameter int LENGTH      = 20,
    parameter int DATA_WIDTH  = 8,
    parameter int COEFF_WIDTH = 8,
    parameter int OUT_WIDTH   = 16,
    parameter int SHIFT       = 0
) (
    input  logic               clock,
    input  logic               reset,
    n_tap_fir_stream_if.slave  bus
);

    localparam int ACC_WIDTH = acc_width(DATA_WIDTH, COEFF_WIDTH, LENGTH);
    localparam int CNT_WIDTH = $clog2(LENGTH);

    fir_state_t                    state;
    logic [CNT_WIDTH-1:0]          count;
    logic                          coef_set;
    logic signed [COEFF_WIDTH-1:0] coef [LENGTH];
    logic signed [ACC_WIDTH-1:0]   tap  [LENGTH-1];
    logic signed [ACC_WIDTH-1:0]   prod [LENGTH];
    logic signed [ACC_WIDTH-1:0]   x_ext;
    logic                          accept;
    logic                          step;
    logic                          coef_last;
    logic                          flush_last;
    logic                          clear_taps;
    logic signed [ACC_WIDTH-1:0]   acc_p1;
    logic                          vld_p1;
    logic                          last_p1;

    assign bus.dataInReady  = (state == ST_RUN);
    assign bus.coeffSetFlag = coef_set;

    // One counter serves both LOAD (coefficient index) and FLUSH (zeros injected).
    always_comb begin
        accept     = bus.dataValid & bus.dataInReady;
        step       = accept | (state == ST_FLUSH);
        coef_last  = (state == ST_LOAD) & bus.coeffValid & (count == CNT_WIDTH'(LENGTH - 1));
        flush_last = (state == ST_FLUSH) & (count == CNT_WIDTH'(LENGTH - 2));
        clear_taps = bus.loadCoeff | coef_last;
        x_ext      = '0;
        if (state != ST_FLUSH)
            x_ext = $signed({{(ACC_WIDTH-DATA_WIDTH){bus.dataIn[DATA_WIDTH-1]}}, bus.dataIn});
        for (int k = 0; k < LENGTH; k++)
            prod[k] = x_ext * $signed({{(ACC_WIDTH-COEFF_WIDTH){coef[k][COEFF_WIDTH-1]}}, coef[k]});
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            coef_set <= 1'b0;
        end else if (bus.loadCoeff) begin
            state    <= ST_LOAD;
            count    <= '0;
            coef_set <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (coef_last) begin
                        state    <= ST_RUN;
                        count    <= '0;
                        coef_set <= 1'b1;
                    end else if (bus.coeffValid) begin
                        count <= count + 1'b1;
                    end
                end
                ST_RUN: begin
                    if (bus.stopDataLoadFlag) begin
                        state <= ST_FLUSH;
                        count <= '0;
                    end
                end
                ST_FLUSH: begin
                    if (flush_last) begin
                        state <= ST_RUN;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LENGTH; k++) coef[k] <= '0;
        end else if (!bus.loadCoeff && state == ST_LOAD && bus.coeffValid) begin
            coef[count] <= bus.coeffIn;
        end
    end

    // Stage 1: transposed tap chain; tap[0] plus h[0]*x is the finished y[n].
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < LENGTH-1; k++) tap[k] <= '0;
            acc_p1  <= '0;
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end else begin
            vld_p1  <= step & ~bus.loadCoeff;
            last_p1 <= flush_last & ~bus.loadCoeff;
            if (clear_taps) begin
                for (int k = 0; k < LENGTH-1; k++) tap[k] <= '0;
            end else if (step) begin
                acc_p1 <= prod[0] + tap[0];
                for (int k = 0; k < LENGTH-2; k++) tap[k] <= prod[k+1] + tap[k+1];
                tap[LENGTH-2] <= prod[LENGTH-1];
            end
        end
    end

    fir_sat_shift #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH),
        .SHIFT     (SHIFT)
    ) u_sat_shift (
        .clock   (clock),
        .reset   (reset),
        .clear   (bus.loadCoeff),
        .vld_p1  (vld_p1),
        .last_p1 (last_p1),
        .acc_p1  (acc_p1),
        .vld_p2  (bus.dataOutValid),
        .last_p2 (bus.flushDone),
        .data_p2 (bus.dataOut)
    );

endmodule

// File: doc/n_tap_fir_stream.md
# n_tap_fir_stream

Parametrised streaming FIR filter; next generation of the n_tap_fir block. Adds independent data, coefficient and output widths, a valid/ready input handshake, a coefficient load state machine, and configurable output scaling with saturation. It also adds automatic zero-padding flush that yields the complete linear convolution without the source supplying LENGTH-1 zeros. Sits between the sample source and the matched-filter/detection stages.

## Interface
- LENGTH, 20, number of taps (≥2)
- DATA_WIDTH, 8, signed input sample width
- COEFF_WIDTH, 8, signed coefficient width
- OUT_WIDTH, 16, signed output width after scaling/saturation
- SHIFT, 0, arithmetic right-shift applied to the accumulator before saturation (0 ≤ SHIFT < ACC_WIDTH)
- clock  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-low reset
- loadCoeff  in  1  one-cycle pulse: start (or restart) coefficient load
- coeffValid  in  1  coeffIn valid this cycle
- coeffIn  in  COEFF_WIDTH  coefficient, first accepted = h[0]
- coeffSetFlag  out  1  high while a full coefficient set is loaded
- dataValid  in  1  dataIn valid
- dataInReady  out  1  block accepts dataIn this cycle
- dataIn  in  DATA_WIDTH  signed sample
- stopDataLoadFlag  in  1  one-cycle pulse: flush delay line with LENGTH-1 zeros
- dataOutValid  out  1  dataOut valid
- dataOut  out  OUT_WIDTH  filtered, scaled, saturated sample
- flushDone  out  1  one-cycle pulse with the last flush output

## Operation
- ACC_WIDTH = DATA_WIDTH + COEFF_WIDTH + $clog2(LENGTH); all products and sums full precision, sign-extended, no internal overflow.
- Transposed-form structure: y[n] = Σ h[k]·x[n−k], k = 0..LENGTH−1.
- States: IDLE, LOAD, RUN, FLUSH.
- IDLE: after reset; dataInReady=0. loadCoeff → LOAD.
- LOAD: coefficient counter 0..LENGTH−1; each coeffValid writes h[count]. After the LENGTH-th write: coeffSetFlag=1, delay line cleared, → RUN. coeffValid outside LOAD is ignored.
- RUN: dataInReady=1; sample accepted when dataValid & dataInReady. Each accepted sample produces exactly one output.
- RUN + stopDataLoadFlag → FLUSH. If dataValid is in the same cycle, that sample is accepted first.
- FLUSH: dataInReady=0; injects LENGTH−1 zero samples on consecutive cycles. flushDone accompanies the output of the last zero. Delay line then holds zeros → RUN.
- loadCoeff in any state: coeffSetFlag=0, delay line cleared, counter=0, in-flight outputs discarded (dataOutValid forced 0), → LOAD. stopDataLoadFlag outside RUN is ignored.
- Output: acc >>> SHIFT (floor), then clip to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].

## Timing
- Reset values: coeffSetFlag=0, dataInReady=0, dataOutValid=0, dataOut=0, flushDone=0, state=IDLE, all coefficients and delay registers 0.
- Latency: 2 cycles from accepted sample (or injected zero) to dataOutValid. Stage 1 is the tap/accumulate register; stage 2 is the shift/saturate register.
- Throughput: one sample per cycle in RUN and FLUSH.
- The first RUN cycle follows the cycle of the final coeffValid in LOAD.
- Asynchronous reset mid-LOAD/RUN/FLUSH returns immediately to reset values; coefficients are lost.
- No output backpressure; the consumer must accept every dataOutValid.

## Structure
- Shared package fir_pkg: state enum (IDLE/LOAD/RUN/FLUSH), ACC_WIDTH function, saturate function.
- One sub-module: fir_sat_shift (registered shift + clip stage, parametrised ACC_WIDTH/OUT_WIDTH/SHIFT).
- Top holds FSM, coefficient registers and transposed tap chain.

## Test plan
- Impulse: LENGTH=4, coeffs 1,2,3,4; input 10,0,0,0 → outputs 10,20,30,40; first valid 2 cycles after accept.
- Flush: LENGTH=4, coeffs 1,1,1,1; input 1,1 then stopDataLoadFlag → outputs 1,2,2,2,1; flushDone with final 1; dataInReady low for 3 cycles.
- Saturation: OUT_WIDTH=8, SHIFT=0, coeffs all 127, input 127 ×4 → 127 clipped. Input −128 ×4 → −128.
- Shift: SHIFT=2, coeffs 1,0,0,0, input −5 → −2 (floor).
- Reload mid-stream: loadCoeff during RUN with data flowing → dataOutValid drops next cycle; coeffSetFlag=0 until LENGTH new coeffs. Afterwards the impulse response matches the new set with no residue from old samples.
- Async reset asserted mid-FLUSH → all outputs 0 immediately; loadCoeff required before data is accepted again.
